// File: rtl/oled_text_buffer.sv
`timescale 1ns/1ps
// Character-stream front end for the Pmod OLED: a 4x16 text buffer with cursor,
// terminal-style control codes and a one-cycle update pulse per visible change.
module oled_text_buffer #(
  parameter bit AUTO_SCROLL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic         char_ready,
  input  logic         clear,
  output logic [511:0] display_data,
  output logic [5:0]   cursor_pos,
  output logic         update,
  output logic         busy
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned ROW   = 16;
  localparam int unsigned AW    = 6;

  localparam logic [7:0]    SPACE      = 8'h20;
  localparam logic [7:0]    CH_BS      = 8'h08;
  localparam logic [7:0]    CH_LF      = 8'h0A;
  localparam logic [7:0]    CH_FF      = 8'h0C;
  localparam logic [7:0]    CH_CR      = 8'h0D;
  localparam logic [AW-1:0] LAST_POS   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] SCROLL_POS = AW'(DEPTH - ROW);

  typedef enum logic [2:0] {IDLE, EXEC, SCROLL, CLEAR, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    char_q;
  logic [AW-1:0] pos_q, pos_nxt;
  logic [AW-1:0] cnt_q, cnt_nxt;
  logic          pend_q, pend_nxt;
  logic          dirty_q, dirty_nxt;
  logic          wr_en, scroll_en, ld_char;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_byte;

  // Ready depends only on registered state and the clear request.
  assign char_ready = rst && (state == IDLE) && !clear && !pend_q;
  assign busy       = (state != IDLE);
  assign update     = (state == DONE) && dirty_q;
  assign cursor_pos = pos_q;

  // Flatten the byte array: index 0 lands in the top byte of display_data.
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign display_data[(DEPTH-1-g)*8 +: 8] = mem_q[g];
  end

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_q;
    cnt_nxt   = cnt_q;
    pend_nxt  = pend_q;
    dirty_nxt = dirty_q;
    wr_en     = 1'b0;
    wr_addr   = pos_q;
    wr_byte   = SPACE;
    scroll_en = 1'b0;
    ld_char   = 1'b0;

    if (clear && (state != IDLE)) pend_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (clear || pend_q) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end else if (char_valid) begin
          ld_char   = 1'b1;
          dirty_nxt = 1'b0;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
        if ((char_q >= 8'h20) && (char_q <= 8'h7E)) begin
          wr_en     = 1'b1;
          wr_byte   = char_q;
          dirty_nxt = 1'b1;
          if (pos_q != LAST_POS)  pos_nxt   = pos_q + AW'(1);
          else if (AUTO_SCROLL)   state_nxt = SCROLL;
          else                    pos_nxt   = '0;
        end else begin
          case (char_q)
            CH_LF: begin
              dirty_nxt = 1'b1;
              if (pos_q[5:4] != 2'd3) pos_nxt   = {pos_q[5:4] + 2'd1, 4'd0};
              else if (AUTO_SCROLL)   state_nxt = SCROLL;
              else                    pos_nxt   = '0;
            end
            CH_CR: begin
              if (pos_q[3:0] != 4'd0) begin
                pos_nxt   = {pos_q[5:4], 4'd0};
                dirty_nxt = 1'b1;
              end
            end
            CH_BS: begin
              if (pos_q != '0) begin
                pos_nxt   = pos_q - AW'(1);
                wr_en     = 1'b1;
                wr_addr   = pos_q - AW'(1);
                dirty_nxt = 1'b1;
              end
            end
            CH_FF: begin
              state_nxt = CLEAR;
              cnt_nxt   = '0;
            end
            default: ;
          endcase
        end
      end
      SCROLL: begin
        scroll_en = 1'b1;
        pos_nxt   = SCROLL_POS;
        dirty_nxt = 1'b1;
        state_nxt = DONE;
      end
      CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = cnt_q;
        cnt_nxt   = cnt_q + AW'(1);
        dirty_nxt = 1'b1;
        if (cnt_q == LAST_POS) begin
          pos_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dirty_q <= 1'b0;
      char_q  <= '0;
    end else begin
      state   <= state_nxt;
      pos_q   <= pos_nxt;
      cnt_q   <= cnt_nxt;
      pend_q  <= pend_nxt;
      dirty_q <= dirty_nxt;
      if (ld_char) char_q <= char_in;
    end
  end

  // Text buffer: reset to spaces, one-line scroll, or single-byte write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= SPACE;
    end else if (scroll_en) begin
      for (int i = 0; i < DEPTH - ROW; i++) mem_q[i] <= mem_q[i+ROW];
      for (int i = DEPTH - ROW; i < DEPTH; i++) mem_q[i] <= SPACE;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_byte;
    end
  end

endmodule
